// File: rtl/inst_prefetch_queue.sv
// Instruction prefetch queue: sequential ROM fetch into a DEPTH-entry, PC-tagged FIFO for decode.
// Define FETCH_BYPASS_EN to forward a ROM response straight to decode when the FIFO is empty.
module inst_prefetch_queue #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned IW    = 9,
  parameter int unsigned AW    = 10
) (
  input  logic                   Clk,
  input  logic                   Reset,
  input  logic                   Start,
  input  logic                   RedirectEn,
  input  logic [AW-1:0]          RedirectPc,
  output logic                   RomRdEn,
  output logic [AW-1:0]          RomAddr,
  input  logic [IW-1:0]          RomData,
  output logic                   InstValid,
  input  logic                   InstReady,
  output logic [IW-1:0]          Inst,
  output logic [AW-1:0]          InstPc,
  output logic [$clog2(DEPTH):0] Count
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [AW-1:0] fetchPcQ, fetchPcD;
  logic          inFlightQ, inFlightD;
  logic [AW-1:0] inFlightPcQ, inFlightPcD;
  logic [PW-1:0] headQ, headD, tailQ, tailD;
  logic [CW-1:0] countQ, countD;
  logic [IW-1:0] memInstQ [DEPTH];
  logic [AW-1:0] memPcQ [DEPTH];

  logic          issue, respValid, push, pop, fifoEmpty;
  logic [CW:0]   creditsUsed;

  // The in-flight read already owns a slot, so it counts against the FIFO credit.
  assign creditsUsed = {1'b0, countQ} + {{CW{1'b0}}, inFlightQ};
  assign issue       = Reset & ~Start & ~RedirectEn & (creditsUsed < (CW+1)'(DEPTH));
  assign respValid   = inFlightQ & ~RedirectEn;
  assign fifoEmpty   = (countQ == '0);

  assign RomRdEn = issue;
  assign RomAddr = fetchPcQ;
  assign Count   = countQ;

`ifdef FETCH_BYPASS_EN
  logic bypassTaken;

  assign bypassTaken = respValid & fifoEmpty;

  always_comb begin
    if (bypassTaken) begin
      InstValid = 1'b1;
      Inst      = RomData;
      InstPc    = inFlightPcQ;
    end else begin
      InstValid = ~fifoEmpty;
      Inst      = memInstQ[headQ];
      InstPc    = memPcQ[headQ];
    end
  end

  // A forwarded response that decode accepts never occupies a FIFO slot.
  assign push = respValid & ~(bypassTaken & InstReady);
`else
  assign InstValid = ~fifoEmpty;
  assign Inst      = memInstQ[headQ];
  assign InstPc    = memPcQ[headQ];
  assign push      = respValid;
`endif

  assign pop = InstReady & ~fifoEmpty & ~RedirectEn;

  always_comb begin
    fetchPcD    = fetchPcQ;
    inFlightD   = inFlightQ;
    inFlightPcD = inFlightPcQ;
    headD       = headQ;
    tailD       = tailQ;
    countD      = countQ;
    if (RedirectEn) begin
      fetchPcD  = RedirectPc;
      inFlightD = 1'b0;
      headD     = '0;
      tailD     = '0;
      countD    = '0;
    end else begin
      inFlightD = issue;
      if (issue) begin
        inFlightPcD = fetchPcQ;
        fetchPcD    = fetchPcQ + AW'(1);
      end
      if (push) tailD = tailQ + PW'(1);
      if (pop)  headD = headQ + PW'(1);
      case ({push, pop})
        2'b10:   countD = countQ + CW'(1);
        2'b01:   countD = countQ - CW'(1);
        default: countD = countQ;
      endcase
    end
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      fetchPcQ    <= '0;
      inFlightQ   <= 1'b0;
      inFlightPcQ <= '0;
      headQ       <= '0;
      tailQ       <= '0;
      countQ      <= '0;
    end else begin
      fetchPcQ    <= fetchPcD;
      inFlightQ   <= inFlightD;
      inFlightPcQ <= inFlightPcD;
      headQ       <= headD;
      tailQ       <= tailD;
      countQ      <= countD;
    end
  end

  // Storage is cleared on reset so Inst/InstPc read back as zero while idle.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      memInstQ <= '{default: '0};
      memPcQ   <= '{default: '0};
    end else if (push) begin
      memInstQ[tailQ] <= RomData;
      memPcQ[tailQ]   <= inFlightPcQ;
    end
  end

endmodule

// File: tb/tb_inst_prefetch_queue.sv
// Scoreboard bench for inst_prefetch_queue: expected (pc, inst) stream is rebuilt from the ROM image
// on every reset/redirect; a negedge monitor pops and compares each decode handshake.
module tb_inst_prefetch_queue;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned IW    = 9;
  localparam int unsigned AW    = 10;
`ifdef FETCH_BYPASS_EN
  localparam int LAT  = 1;
  localparam int LATR = 2;
`else
  localparam int LAT  = 2;
  localparam int LATR = 3;
`endif

  typedef struct packed {
    logic [AW-1:0] pc;
    logic [IW-1:0] inst;
  } expT;

  logic                   Clk, Reset, Start, RedirectEn;
  logic [AW-1:0]          RedirectPc;
  logic                   RomRdEn;
  logic [AW-1:0]          RomAddr;
  logic [IW-1:0]          RomData;
  logic                   InstValid, InstReady;
  logic [IW-1:0]          Inst;
  logic [AW-1:0]          InstPc;
  logic [$clog2(DEPTH):0] Count;

  logic [IW-1:0] rom [1 << AW];
  expT           expQ [$];
  expT           e;
  logic [AW-1:0] nextPc, issuePc;
  int            vectors = 0;
  int            miscompares = 0;
  int            pulses;

  inst_prefetch_queue #(
    .DEPTH (DEPTH),
    .IW    (IW),
    .AW    (AW)
  ) dut (
    .Clk        (Clk),
    .Reset      (Reset),
    .Start      (Start),
    .RedirectEn (RedirectEn),
    .RedirectPc (RedirectPc),
    .RomRdEn    (RomRdEn),
    .RomAddr    (RomAddr),
    .RomData    (RomData),
    .InstValid  (InstValid),
    .InstReady  (InstReady),
    .Inst       (Inst),
    .InstPc     (InstPc),
    .Count      (Count)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Synchronous ROM; garbage on idle cycles so stale data is never mistaken for a response.
  always @(posedge Clk) RomData <= RomRdEn ? rom[RomAddr] : IW'($urandom);

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void topUp();
    while (expQ.size() < 16) begin
      expQ.push_back('{pc: nextPc, inst: rom[nextPc]});
      nextPc = nextPc + AW'(1);
    end
  endfunction

  function automatic void restartAt(input logic [AW-1:0] pc);
    expQ.delete();
    nextPc  = pc;
    issuePc = pc;
    topUp();
  endfunction

  task automatic tick();
    @(posedge Clk);
    #1;
    topUp();
  endtask

  task automatic doRedirect(input logic [AW-1:0] pc);
    RedirectPc = pc;
    RedirectEn = 1'b1;
    restartAt(pc);
    tick();
    RedirectEn = 1'b0;
  endtask

  task automatic checkOutputsZero(input string tag);
    check({tag, "InstValid"}, 32'(InstValid), 32'd0);
    check({tag, "RomRdEn"},   32'(RomRdEn),   32'd0);
    check({tag, "RomAddr"},   32'(RomAddr),   32'd0);
    check({tag, "Inst"},      32'(Inst),      32'd0);
    check({tag, "InstPc"},    32'(InstPc),    32'd0);
    check({tag, "Count"},     32'(Count),     32'd0);
  endtask

  // Called at posedge+1 of the first cycle after reset release, InstReady high.
  task automatic startupCheck(input int n);
    for (int c = 0; c < n; c++) begin
      @(negedge Clk);
      if (c < LAT) begin
        check("startupValid", 32'(InstValid), 32'd0);
      end else begin
        check("streamValid", 32'(InstValid), 32'd1);
        check("streamCount", 32'(Count <= 1), 32'd1);
      end
      if (c == LAT) check("firstPc", 32'(InstPc), 32'd0);
      tick();
    end
  endtask

  always @(negedge Clk) begin
    if (Reset === 1'b1) begin
      if (Start || RedirectEn) check("romHold", 32'(RomRdEn), 32'd0);
      if (RomRdEn) begin
        check("romAddr", 32'(RomAddr), 32'(issuePc));
        issuePc = issuePc + AW'(1);
      end
      if (InstValid && InstReady && !RedirectEn) begin
        if (expQ.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL sbUnderflow: got handshake pc 0x%0h, expected none", InstPc);
        end else begin
          e = expQ.pop_front();
          check("instPc", 32'(InstPc), 32'(e.pc));
          check("inst",   32'(Inst),   32'(e.inst));
        end
      end
      check("countBound", 32'(Count <= DEPTH), 32'd1);
    end
  end

  initial begin
    logic [AW-1:0] wpc;
    for (int i = 0; i < (1 << AW); i++) rom[i] = IW'($urandom);
    Reset      = 1'b0;
    Start      = 1'b0;
    RedirectEn = 1'b0;
    RedirectPc = '0;
    InstReady  = 1'b1;
    restartAt('0);

    repeat (2) @(posedge Clk);
    @(negedge Clk);
    checkOutputsZero("rst");
    @(posedge Clk);
    #1;
    Reset = 1'b1;
    startupCheck(12);

    // Backpressure: exactly DEPTH reads, then a gap-free drain.
    InstReady = 1'b0;
    doRedirect(10'h000);
    pulses = 0;
    repeat (10) begin
      @(negedge Clk);
      if (RomRdEn) pulses++;
      tick();
    end
    check("fillPulses", 32'(pulses), 32'd4);
    @(negedge Clk);
    check("fillCount",  32'(Count),     32'd4);
    check("fillValid",  32'(InstValid), 32'd1);
    check("fillHeadPc", 32'(InstPc),    32'd0);
    tick();
    InstReady = 1'b1;
    repeat (12) begin
      @(negedge Clk);
      check("drainValid", 32'(InstValid), 32'd1);
      tick();
    end

    // Redirect with three buffered and one in flight.
    InstReady = 1'b0;
    doRedirect(10'h020);
    for (int i = 0; i < 20 && Count != 3; i++) tick();
    check("fill3", 32'(Count), 32'd3);
    InstReady = 1'b1;
    doRedirect(10'h155);
    for (int c = 1; c <= LATR; c++) begin
      @(negedge Clk);
      if (c == 1) check("flushCount", 32'(Count), 32'd0);
      check("redirValid", 32'(InstValid), 32'(c == LATR));
      if (c == LATR) check("redirPc", 32'(InstPc), 32'h155);
      tick();
    end

    // PC wrap.
    doRedirect(10'h3FF);
    for (int c = 1; c <= LATR + 2; c++) begin
      @(negedge Clk);
      if (c >= LATR) begin
        wpc = 10'h3FF + AW'(c - LATR);
        check("wrapValid", 32'(InstValid), 32'd1);
        check("wrapPc", 32'(InstPc), 32'(wpc));
      end
      tick();
    end

    // Start hold mid-stream.
    InstReady = 1'b0;
    repeat (3) tick();
    Start     = 1'b1;
    InstReady = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge Clk);
      check("startHold", 32'(RomRdEn), 32'd0);
      if (c == 0) check("startDrain", 32'(InstValid), 32'd1);
      tick();
    end
    Start = 1'b0;
    repeat (10) tick();

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      InstReady = ($urandom_range(0, 9) < 7);
      Start     = ($urandom_range(0, 9) == 0);
      if ($urandom_range(0, 39) == 0) doRedirect(AW'($urandom));
      else tick();
    end
    Start     = 1'b0;
    InstReady = 1'b1;
    repeat (6) tick();

    // Asynchronous reset with two entries buffered.
    InstReady = 1'b0;
    for (int i = 0; i < 20 && Count != 2; i++) tick();
    check("rst2Count", 32'(Count), 32'd2);
    #1;
    Reset = 1'b0;
    restartAt('0);
    #1;
    checkOutputsZero("midRst");
    @(posedge Clk);
    #1;
    Reset     = 1'b1;
    InstReady = 1'b1;
    startupCheck(10);
    repeat (5) tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
